// File: rtl/xenos_pkg.sv
// rtl/xenos_pkg.sv - shared fault-bit and channel-state types for the boundary monitor
//
// Purpose : common enums for xenos_bnd_chan and xenos_boundary_monitor.
// Contents: fault_bit_e  - one-hot fault bits in {OT, OC, UV, OV} order (bit3..0)
//           chan_state_e - per-channel debounce FSM states
package xenos_pkg;

    localparam int FAULT_W = 4;

    typedef enum logic [FAULT_W-1:0] {
        NO_FAULT     = 4'b0000,
        OVER_VOLT    = 4'b0001,
        UNDER_VOLT   = 4'b0010,
        OVER_CURRENT = 4'b0100,
        OVER_TEMP    = 4'b1000
    } fault_bit_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_PEND  = 2'd1,
        ST_FAULT = 2'd2,
        ST_RECOV = 2'd3
    } chan_state_e;

endpackage

// File: rtl/xenos_bnd_chan.sv
// rtl/xenos_bnd_chan.sv - one channel of the boundary monitor: limit compare, debounce FSM, fault bits
//
// Purpose : compares one sample stream against its limits, debounces entry into
//           and exit from the fault condition, and keeps active and sticky fault bits.
// Ports   : clk, rst_n           - clock, asynchronous active-low reset
//           valid_i              - sample strobe; no strobe means everything holds
//           volt_i/cur_i/temp_i  - sample fields
//           volt_min_i .. temp_max_i - channel limits
//           hyst_v_i/c_i/t_i     - clear hysteresis
//           assert_cnt_i/clear_cnt_i - debounce counts
//           fault_clr_i          - sticky-clear pulse
//           fault_o              - channel in FAULT or RECOV
//           code_o / sticky_o    - active / latched fault bits {OT, OC, UV, OV}
//           entry_o              - one-cycle flag: channel entered FAULT from OK/PEND
module xenos_bnd_chan
    import xenos_pkg::*;
#(
    parameter int VW    = 16,
    parameter int CW    = 8,
    parameter int TW    = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [VW-1:0]      volt_i,
    input  logic [CW-1:0]      cur_i,
    input  logic [TW-1:0]      temp_i,
    input  logic [VW-1:0]      volt_min_i,
    input  logic [VW-1:0]      volt_max_i,
    input  logic [CW-1:0]      cur_max_i,
    input  logic [TW-1:0]      temp_max_i,
    input  logic [VW-1:0]      hyst_v_i,
    input  logic [CW-1:0]      hyst_c_i,
    input  logic [TW-1:0]      hyst_t_i,
    input  logic [CNT_W-1:0]   assert_cnt_i,
    input  logic [CNT_W-1:0]   clear_cnt_i,
    input  logic               fault_clr_i,
    output logic               fault_o,
    output logic [FAULT_W-1:0] code_o,
    output logic [FAULT_W-1:0] sticky_o,
    output logic               entry_o
);

    chan_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FAULT_W-1:0] code_q;
    logic [FAULT_W-1:0] sticky_q;
    logic               fault_q;
    logic               entry_q;

    logic [FAULT_W-1:0] raw;
    logic               raw_any;
    logic [VW-1:0]      v_hi;
    logic [VW-1:0]      v_lo;
    logic [VW:0]        v_lo_sum;
    logic [CW-1:0]      c_hi;
    logic [TW-1:0]      t_hi;
    logic               clear_ok;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;
    logic               assert_hit;
    logic               clear_hit;
    logic               assert_le1;
    logic               clear_le1;
    logic               going_fault;
    logic               in_alarm;
    logic [FAULT_W-1:0] set_bits;

    always_comb begin
        raw = NO_FAULT;
        if (volt_i > volt_max_i) raw = raw | OVER_VOLT;
        if (volt_i < volt_min_i) raw = raw | UNDER_VOLT;
        if (cur_i  > cur_max_i)  raw = raw | OVER_CURRENT;
        if (temp_i > temp_max_i) raw = raw | OVER_TEMP;
        raw_any = |raw;

        // Clear thresholds are pulled inside the limits by the hysteresis,
        // saturating instead of wrapping so a large hysteresis never re-opens the window.
        v_hi     = (volt_max_i >= hyst_v_i) ? (volt_max_i - hyst_v_i) : '0;
        v_lo_sum = {1'b0, volt_min_i} + {1'b0, hyst_v_i};
        v_lo     = v_lo_sum[VW] ? '1 : v_lo_sum[VW-1:0];
        c_hi     = (cur_max_i  >= hyst_c_i) ? (cur_max_i  - hyst_c_i) : '0;
        t_hi     = (temp_max_i >= hyst_t_i) ? (temp_max_i - hyst_t_i) : '0;
        clear_ok = (volt_i <= v_hi) && (volt_i >= v_lo) &&
                   (cur_i <= c_hi) && (temp_i <= t_hi);

        // Count compared one bit wider so the increment can't wrap; >= lets a
        // count lowered mid-debounce below the current progress fire on the next sample.
        cnt_sum    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        cnt_sat    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        assert_hit = cnt_sum >= {1'b0, assert_cnt_i};
        clear_hit  = cnt_sum >= {1'b0, clear_cnt_i};
        assert_le1 = assert_cnt_i <= CNT_W'(1);
        clear_le1  = clear_cnt_i  <= CNT_W'(1);

        going_fault = valid_i && raw_any &&
                      (((state_q == ST_OK) && assert_le1) ||
                       ((state_q == ST_PEND) && assert_hit));
        in_alarm    = (state_q == ST_FAULT) || (state_q == ST_RECOV);
        set_bits    = (valid_i && (going_fault || in_alarm)) ? raw : NO_FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OK;
            cnt_q    <= '0;
            code_q   <= '0;
            sticky_q <= '0;
            fault_q  <= 1'b0;
            entry_q  <= 1'b0;
        end else begin
            entry_q  <= going_fault;
            // Clear first, then OR in this sample's bits: a simultaneous set survives.
            sticky_q <= (fault_clr_i ? '0 : sticky_q) | set_bits;
            if (valid_i) begin
                case (state_q)
                    ST_OK: begin
                        if (raw_any) begin
                            if (assert_le1) begin
                                state_q <= ST_FAULT;
                                cnt_q   <= '0;
                                code_q  <= raw;
                                fault_q <= 1'b1;
                            end else begin
                                state_q <= ST_PEND;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_PEND: begin
                        if (raw_any) begin
                            if (assert_hit) begin
                                state_q <= ST_FAULT;
                                cnt_q   <= '0;
                                code_q  <= raw;
                                fault_q <= 1'b1;
                            end else begin
                                cnt_q   <= cnt_sat;
                            end
                        end else begin
                            state_q <= ST_OK;
                            cnt_q   <= '0;
                        end
                    end
                    ST_FAULT: begin
                        if (clear_ok) begin
                            if (clear_le1) begin
                                state_q <= ST_OK;
                                cnt_q   <= '0;
                                code_q  <= '0;
                                fault_q <= 1'b0;
                            end else begin
                                state_q <= ST_RECOV;
                                cnt_q   <= CNT_W'(1);
                                code_q  <= code_q | raw;
                            end
                        end else begin
                            code_q <= code_q | raw;
                        end
                    end
                    ST_RECOV: begin
                        if (clear_ok) begin
                            if (clear_hit) begin
                                state_q <= ST_OK;
                                cnt_q   <= '0;
                                code_q  <= '0;
                                fault_q <= 1'b0;
                            end else begin
                                cnt_q   <= cnt_sat;
                                code_q  <= code_q | raw;
                            end
                        end else begin
                            // Re-entry from RECOV is not a new fault event: no entry flag.
                            state_q <= ST_FAULT;
                            cnt_q   <= '0;
                            code_q  <= code_q | raw;
                        end
                    end
                    default: begin
                        state_q <= ST_OK;
                        cnt_q   <= '0;
                        code_q  <= '0;
                        fault_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fault_o  = fault_q;
    assign code_o   = code_q;
    assign sticky_o = sticky_q;
    assign entry_o  = entry_q;

endmodule

// File: rtl/xenos_boundary_monitor.sv
// rtl/xenos_boundary_monitor.sv - multi-channel voltage/current/temperature boundary monitor
//
// Purpose : N_CH independent debounced limit monitors plus global summary outputs.
// Ports   : clk, rst_n                    - clock, asynchronous active-low reset
//           xsm_valid[N_CH]              - per-channel sample strobe
//           xsm_data[N_CH x DW]          - samples packed {temp, current, volt}
//           volt_min/volt_max/cur_max/temp_max - per-channel limits
//           hyst_v/hyst_c/hyst_t         - global clear hysteresis
//           assert_cnt/clear_cnt         - debounce counts
//           fault_clr[N_CH]              - sticky-clear pulses
//           channel_fault/fault_code/fault_sticky - per-channel status
//           violation                    - any channel faulted
//           fault_irq                    - one-cycle pulse on any new fault entry
module xenos_boundary_monitor
    import xenos_pkg::*;
#(
    parameter int N_CH  = 12,
    parameter int VW    = 16,
    parameter int CW    = 8,
    parameter int TW    = 8,
    parameter int CNT_W = 4,
    parameter int DW    = TW + CW + VW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         xsm_valid,
    input  logic [N_CH*DW-1:0]      xsm_data,
    input  logic [N_CH*VW-1:0]      volt_min,
    input  logic [N_CH*VW-1:0]      volt_max,
    input  logic [N_CH*CW-1:0]      cur_max,
    input  logic [N_CH*TW-1:0]      temp_max,
    input  logic [VW-1:0]           hyst_v,
    input  logic [CW-1:0]           hyst_c,
    input  logic [TW-1:0]           hyst_t,
    input  logic [CNT_W-1:0]        assert_cnt,
    input  logic [CNT_W-1:0]        clear_cnt,
    input  logic [N_CH-1:0]         fault_clr,
    output logic [N_CH-1:0]         channel_fault,
    output logic [N_CH*FAULT_W-1:0] fault_code,
    output logic [N_CH*FAULT_W-1:0] fault_sticky,
    output logic                    violation,
    output logic                    fault_irq
);

    logic [N_CH-1:0] entry;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        xenos_bnd_chan #(
            .VW    (VW),
            .CW    (CW),
            .TW    (TW),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_i      (xsm_valid[i]),
            .volt_i       (xsm_data[i*DW +: VW]),
            .cur_i        (xsm_data[i*DW+VW +: CW]),
            .temp_i       (xsm_data[i*DW+VW+CW +: TW]),
            .volt_min_i   (volt_min[i*VW +: VW]),
            .volt_max_i   (volt_max[i*VW +: VW]),
            .cur_max_i    (cur_max[i*CW +: CW]),
            .temp_max_i   (temp_max[i*TW +: TW]),
            .hyst_v_i     (hyst_v),
            .hyst_c_i     (hyst_c),
            .hyst_t_i     (hyst_t),
            .assert_cnt_i (assert_cnt),
            .clear_cnt_i  (clear_cnt),
            .fault_clr_i  (fault_clr[i]),
            .fault_o      (channel_fault[i]),
            .code_o       (fault_code[i*FAULT_W +: FAULT_W]),
            .sticky_o     (fault_sticky[i*FAULT_W +: FAULT_W]),
            .entry_o      (entry[i])
        );
    end

    // Both are ORs of per-channel registers, so they stay glitch-free and in step
    // with channel_fault; simultaneous entries collapse into one irq pulse.
    assign violation = |channel_fault;
    assign fault_irq = |entry;

endmodule

// File: tb/tb_xenos_boundary_monitor.sv
// tb/tb_xenos_boundary_monitor.sv - directed self-checking bench for xenos_boundary_monitor
module tb_xenos_boundary_monitor;

    localparam int N_CH  = 12;
    localparam int VW    = 16;
    localparam int CW    = 8;
    localparam int TW    = 8;
    localparam int CNT_W = 4;
    localparam int DW    = TW + CW + VW;

    logic                 clk;
    logic                 rst_n;
    logic [N_CH-1:0]      xsm_valid;
    logic [N_CH*DW-1:0]   xsm_data;
    logic [N_CH*VW-1:0]   volt_min;
    logic [N_CH*VW-1:0]   volt_max;
    logic [N_CH*CW-1:0]   cur_max;
    logic [N_CH*TW-1:0]   temp_max;
    logic [VW-1:0]        hyst_v;
    logic [CW-1:0]        hyst_c;
    logic [TW-1:0]        hyst_t;
    logic [CNT_W-1:0]     assert_cnt;
    logic [CNT_W-1:0]     clear_cnt;
    logic [N_CH-1:0]      fault_clr;
    logic [N_CH-1:0]      channel_fault;
    logic [N_CH*4-1:0]    fault_code;
    logic [N_CH*4-1:0]    fault_sticky;
    logic                 violation;
    logic                 fault_irq;

    int vectors;
    int miscompares;

    xenos_boundary_monitor #(
        .N_CH(N_CH), .VW(VW), .CW(CW), .TW(TW), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .xsm_valid     (xsm_valid),
        .xsm_data      (xsm_data),
        .volt_min      (volt_min),
        .volt_max      (volt_max),
        .cur_max       (cur_max),
        .temp_max      (temp_max),
        .hyst_v        (hyst_v),
        .hyst_c        (hyst_c),
        .hyst_t        (hyst_t),
        .assert_cnt    (assert_cnt),
        .clear_cnt     (clear_cnt),
        .fault_clr     (fault_clr),
        .channel_fault (channel_fault),
        .fault_code    (fault_code),
        .fault_sticky  (fault_sticky),
        .violation     (violation),
        .fault_irq     (fault_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_s(input int ch, input int v, input int c, input int t);
        xsm_data[ch*DW +: DW] = {TW'(t), CW'(c), VW'(v)};
    endtask

    // Called at a falling edge: drive for one rising edge, return at the next falling edge.
    task automatic step(input logic [N_CH-1:0] vmask, input logic [N_CH-1:0] cmask);
        xsm_valid = vmask;
        fault_clr = cmask;
        @(negedge clk);
        xsm_valid = '0;
        fault_clr = '0;
    endtask

    function automatic logic [N_CH-1:0] bit_of(input int ch);
        return N_CH'(1) << ch;
    endfunction

    function automatic logic [3:0] code_of(input int ch);
        return fault_code[ch*4 +: 4];
    endfunction

    function automatic logic [3:0] sticky_of(input int ch);
        return fault_sticky[ch*4 +: 4];
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        xsm_valid   = '0;
        fault_clr   = '0;
        hyst_v      = '0;
        hyst_c      = '0;
        hyst_t      = '0;
        assert_cnt  = CNT_W'(3);
        clear_cnt   = CNT_W'(2);
        for (int i = 0; i < N_CH; i++) begin
            volt_min[i*VW +: VW] = VW'(100);
            volt_max[i*VW +: VW] = VW'(1000);
            cur_max[i*CW +: CW]  = CW'(100);
            temp_max[i*TW +: TW] = TW'(100);
            set_s(i, 500, 50, 50);
        end

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_channel_fault", 64'(channel_fault), 64'h0);
        chk("rst_fault_code", 64'(fault_code), 64'h0);
        chk("rst_fault_sticky", 64'(fault_sticky), 64'h0);
        chk("rst_violation", 64'(violation), 64'h0);
        chk("rst_fault_irq", 64'(fault_irq), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three over-voltage samples on ch0 with assert_cnt=3
        set_s(0, 1001, 50, 50);
        step(bit_of(0), '0);
        chk("ov1_fault", 64'(channel_fault[0]), 64'h0);
        step(bit_of(0), '0);
        chk("ov2_fault", 64'(channel_fault[0]), 64'h0);
        chk("ov2_irq", 64'(fault_irq), 64'h0);
        step(bit_of(0), '0);
        chk("ov3_fault", 64'(channel_fault[0]), 64'h1);
        chk("ov3_code", 64'(code_of(0)), 64'h1);
        chk("ov3_irq", 64'(fault_irq), 64'h1);
        chk("ov3_violation", 64'(violation), 64'h1);
        step('0, '0);
        chk("ov_irq_single", 64'(fault_irq), 64'h0);
        chk("ov_hold_fault", 64'(channel_fault[0]), 64'h1);

        // Recovery with hysteresis 50 and clear_cnt=2
        hyst_v = VW'(50);
        set_s(0, 960, 50, 50);
        step(bit_of(0), '0);
        chk("rec960_fault", 64'(channel_fault[0]), 64'h1);
        set_s(0, 940, 50, 50);
        step(bit_of(0), '0);
        chk("rec940a_fault", 64'(channel_fault[0]), 64'h1);
        step(bit_of(0), '0);
        chk("rec940b_fault", 64'(channel_fault[0]), 64'h0);
        chk("rec_code", 64'(code_of(0)), 64'h0);
        chk("rec_sticky", 64'(sticky_of(0)), 64'h1);
        chk("rec_violation", 64'(violation), 64'h0);
        chk("rec_irq", 64'(fault_irq), 64'h0);

        // ch1 debounce aborted by a good sample, and the count restarts
        set_s(1, 1001, 50, 50);
        step(bit_of(1), '0);
        step(bit_of(1), '0);
        set_s(1, 900, 50, 50);
        step(bit_of(1), '0);
        chk("abort_fault", 64'(channel_fault[1]), 64'h0);
        chk("abort_irq", 64'(fault_irq), 64'h0);
        set_s(1, 1001, 50, 50);
        step(bit_of(1), '0);
        step(bit_of(1), '0);
        chk("restart_fault", 64'(channel_fault[1]), 64'h0);
        set_s(1, 900, 50, 50);
        step(bit_of(1), '0);

        // ch2 boundary values, immediate assert, RECOV->FAULT re-entry without irq
        assert_cnt = CNT_W'(1);
        set_s(2, 1000, 50, 50);
        step(bit_of(2), '0);
        chk("edge1000_fault", 64'(channel_fault[2]), 64'h0);
        set_s(2, 99, 50, 50);
        step(bit_of(2), '0);
        chk("uv_fault", 64'(channel_fault[2]), 64'h1);
        chk("uv_code", 64'(code_of(2)), 64'h2);
        chk("uv_irq", 64'(fault_irq), 64'h1);
        set_s(2, 500, 50, 50);
        step(bit_of(2), '0);
        chk("uv_recov_fault", 64'(channel_fault[2]), 64'h1);
        set_s(2, 99, 50, 50);
        step(bit_of(2), '0);
        chk("reentry_fault", 64'(channel_fault[2]), 64'h1);
        chk("reentry_irq", 64'(fault_irq), 64'h0);
        set_s(2, 500, 50, 50);
        step(bit_of(2), '0);
        step(bit_of(2), '0);
        chk("uv_clear_fault", 64'(channel_fault[2]), 64'h0);
        chk("uv_sticky", 64'(sticky_of(2)), 64'h2);

        // ch3 over-temp and ch7 over-current on the same edge
        hyst_v = '0;
        set_s(3, 500, 50, 101);
        set_s(7, 500, 101, 50);
        step(bit_of(3) | bit_of(7), '0);
        chk("dual_faults", 64'(channel_fault), 64'h088);
        chk("dual_code3", 64'(code_of(3)), 64'h8);
        chk("dual_code7", 64'(code_of(7)), 64'h4);
        chk("dual_irq", 64'(fault_irq), 64'h1);
        step('0, '0);
        chk("dual_irq_single", 64'(fault_irq), 64'h0);

        // ch3 back to OK, then fault_clr coincident with a new entry
        set_s(3, 500, 50, 50);
        step(bit_of(3), '0);
        step(bit_of(3), '0);
        chk("ch3_ok_fault", 64'(channel_fault[3]), 64'h0);
        chk("ch3_ok_sticky", 64'(sticky_of(3)), 64'h8);
        set_s(3, 1001, 50, 50);
        step(bit_of(3), bit_of(3));
        chk("clr_set_sticky", 64'(sticky_of(3)), 64'h1);
        chk("clr_set_code", 64'(code_of(3)), 64'h1);
        chk("clr_set_irq", 64'(fault_irq), 64'h1);
        step('0, bit_of(3));
        chk("clr_alone_sticky", 64'(sticky_of(3)), 64'h0);
        chk("clr_alone_fault", 64'(channel_fault[3]), 64'h1);

        // Asynchronous reset while ch5 is mid-debounce
        assert_cnt = CNT_W'(3);
        set_s(5, 1001, 50, 50);
        step(bit_of(5), '0);
        step(bit_of(5), '0);
        chk("pend_fault5", 64'(channel_fault[5]), 64'h0);
        chk("pre_rst_violation", 64'(violation), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_channel_fault", 64'(channel_fault), 64'h0);
        chk("arst_fault_code", 64'(fault_code), 64'h0);
        chk("arst_fault_sticky", 64'(fault_sticky), 64'h0);
        chk("arst_violation", 64'(violation), 64'h0);
        chk("arst_fault_irq", 64'(fault_irq), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(bit_of(5), '0);
        chk("post_rst1_fault5", 64'(channel_fault[5]), 64'h0);
        chk("post_rst1_violation", 64'(violation), 64'h0);
        step(bit_of(5), '0);
        chk("post_rst2_fault5", 64'(channel_fault[5]), 64'h0);
        step(bit_of(5), '0);
        chk("post_rst3_fault5", 64'(channel_fault[5]), 64'h1);
        chk("post_rst3_code5", 64'(code_of(5)), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
